instruction_fetch_unit: RTL and testbench

//   Sequences the 16x16 instruction memory for the CPU front end.

---
 rtl/instruction_fetch_unit.sv | 146 ++++++++++++++
 tb/tb_instruction_fetch_unit.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetch_unit
// Brief    : Front-end fetch sequencer. Holds the PC and drives the combinational
//            read address of the instruction memory. Registers the returned word
//            into the IR and hands the IR to decode over a valid/ready handshake.
//            Supports branch redirect, decode back-pressure and halt detection.
// Revision : 1.0 - initial release
// ============================================================================
module instruction_fetch_unit #(
  parameter int              ADDR_W      = 4,
  parameter int              DATA_W      = 16,
  parameter logic [ADDR_W-1:0] START_ADDR = '0,
  parameter logic [3:0]      HALT_OPCODE = 4'hF
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  output logic [ADDR_W-1:0] instruction_address,
  input  logic [DATA_W-1:0] instruction_data,
  output logic [DATA_W-1:0] ir,
  output logic [ADDR_W-1:0] ir_pc,
  output logic              ir_valid,
  input  logic              ir_ready,
  input  logic              branch_valid,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              halted
);

  // PC step; addition wraps naturally at 2**ADDR_W.
  localparam logic [ADDR_W-1:0] C_PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH  = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_nxt;
  logic [DATA_W-1:0] r_ir;
  logic [DATA_W-1:0] w_ir_nxt;
  logic [ADDR_W-1:0] r_ir_pc;
  logic [ADDR_W-1:0] w_ir_pc_nxt;
  logic              r_ir_valid;
  logic              w_ir_valid_nxt;
  logic              r_halted;
  logic              w_halted_nxt;

  // A capture needs the IR slot free (empty, or being handed over this cycle);
  // a branch in the same cycle takes priority and suppresses it.
  logic              w_slot_free;
  logic              w_capture;
  logic              w_is_halt;

  assign w_slot_free = !r_ir_valid || ir_ready;
  assign w_capture   = (r_state == S_FETCH) && !branch_valid && w_slot_free;

  // Only meaningful when w_capture is high; memory data is not looked at otherwise.
  assign w_is_halt   = (instruction_data[DATA_W-1 -: 4] == HALT_OPCODE);

  // State and datapath registers; clr forces reset values without a clock.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state    <= S_IDLE;
      r_pc       <= START_ADDR;
      r_ir       <= '0;
      r_ir_pc    <= '0;
      r_ir_valid <= 1'b0;
      r_halted   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_ir       <= w_ir_nxt;
      r_ir_pc    <= w_ir_pc_nxt;
      r_ir_valid <= w_ir_valid_nxt;
      r_halted   <= w_halted_nxt;
    end
  end

  // Next-state and next-datapath decode; everything holds unless changed below.
  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_ir_nxt       = r_ir;
    w_ir_pc_nxt    = r_ir_pc;
    w_ir_valid_nxt = r_ir_valid;
    w_halted_nxt   = r_halted;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_FETCH;
          w_pc_nxt    = START_ADDR;
        end
      end

      S_FETCH: begin
        if (branch_valid) begin
          // Redirect and flush; the new target is fetched on the next edge.
          w_pc_nxt       = branch_target;
          w_ir_valid_nxt = 1'b0;
        end else if (w_capture) begin
          w_ir_nxt       = instruction_data;
          w_ir_pc_nxt    = r_pc;
          w_ir_valid_nxt = 1'b1;
          w_pc_nxt       = r_pc + C_PC_ONE;
          if (w_is_halt) begin
            w_state_nxt  = S_HALTED;
            w_halted_nxt = 1'b1;
          end
        end
        // Otherwise decode is stalling us: IR, IR PC, valid and PC all hold.
      end

      S_HALTED: begin
        if (start) begin
          w_state_nxt    = S_FETCH;
          w_pc_nxt       = START_ADDR;
          w_halted_nxt   = 1'b0;
          w_ir_valid_nxt = 1'b0;
        end else if (r_ir_valid && ir_ready) begin
          // Let decode drain the halt word; no further fetches happen here.
          w_ir_valid_nxt = 1'b0;
        end
      end

      default: begin
        w_state_nxt    = S_IDLE;
        w_pc_nxt       = START_ADDR;
        w_ir_valid_nxt = 1'b0;
        w_halted_nxt   = 1'b0;
      end
    endcase
  end

  assign instruction_address = r_pc;
  assign ir                  = r_ir;
  assign ir_pc               = r_ir_pc;
  assign ir_valid            = r_ir_valid;
  assign halted              = r_halted;

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_instruction_fetch_unit
// Brief    : Directed bench for instruction_fetch_unit. Expected IR transfers are
//            queued by the stimulus; a monitor pops one per handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch_unit;

  typedef struct packed {
    logic [15:0] ir;
    logic [3:0]  pc;
  } exp_t;

  logic        clk;
  logic        clr;
  logic        start;
  logic [3:0]  instruction_address;
  logic [15:0] instruction_data;
  logic [15:0] ir;
  logic [3:0]  ir_pc;
  logic        ir_valid;
  logic        ir_ready;
  logic        branch_valid;
  logic [3:0]  branch_target;
  logic        halted;

  logic [15:0] r_mem [0:15];
  exp_t        r_q [$];
  int          total;
  int          bad;

  assign instruction_data = r_mem[instruction_address];

  instruction_fetch_unit #(
    .ADDR_W     (4),
    .DATA_W     (16),
    .START_ADDR (4'h0),
    .HALT_OPCODE(4'hF)
  ) u_dut (
    .clk                (clk),
    .clr                (clr),
    .start              (start),
    .instruction_address(instruction_address),
    .instruction_data   (instruction_data),
    .ir                 (ir),
    .ir_pc              (ir_pc),
    .ir_valid           (ir_valid),
    .ir_ready           (ir_ready),
    .branch_valid       (branch_valid),
    .branch_target      (branch_target),
    .halted             (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] w, input logic [3:0] a);
    exp_t e;
    e.ir = w;
    e.pc = a;
    r_q.push_back(e);
  endtask

  // Monitor: every handshake on the IR port must match the next queued word.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (clr && ir_valid === 1'b1 && ir_ready === 1'b1) begin
        if (r_q.size() == 0) begin
          chk("unexpected_transfer", {12'h0, ir_pc, ir}, 32'hFFFF_FFFF);
        end else begin
          e = r_q.pop_front();
          chk("xfer_ir", {16'h0, ir}, {16'h0, e.ir});
          chk("xfer_ir_pc", {28'h0, ir_pc}, {28'h0, e.pc});
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0;
    bad   = 0;
    for (int i = 0; i < 16; i++) r_mem[i] = 16'(i);
    clr = 1'b0; start = 1'b0; ir_ready = 1'b0;
    branch_valid = 1'b0; branch_target = 4'h0;

    // 1: reset values, then idle with start low.
    tick(); tick();
    chk("rst_addr", {28'h0, instruction_address}, 32'h0);
    chk("rst_valid", {31'h0, ir_valid}, 32'h0);
    chk("rst_halted", {31'h0, halted}, 32'h0);
    chk("rst_ir", {16'h0, ir}, 32'h0);
    clr = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_addr", {28'h0, instruction_address}, 32'h0);
      chk("idle_valid", {31'h0, ir_valid}, 32'h0);
      chk("idle_halted", {31'h0, halted}, 32'h0);
    end

    // 2: stream with ready high, through the 15->0 wrap, up to ir=4.
    for (int i = 0; i < 16; i++) push(16'(i), 4'(i));
    for (int i = 0; i < 4; i++) push(16'(i), 4'(i));
    ir_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    chk("lat_valid_n", {31'h0, ir_valid}, 32'h0);
    tick();
    chk("lat_valid_n1", {31'h0, ir_valid}, 32'h1);
    chk("lat_ir_n1", {16'h0, ir}, 32'h0);
    for (int i = 0; i < 20; i++) tick();
    ir_ready = 1'b0;
    chk("wrap_ir", {16'h0, ir}, 32'h4);
    chk("wrap_addr", {28'h0, instruction_address}, 32'h5);

    // 3: stall three cycles on ir=4, then release.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_ir", {16'h0, ir}, 32'h4);
      chk("stall_ir_pc", {28'h0, ir_pc}, 32'h4);
      chk("stall_addr", {28'h0, instruction_address}, 32'h5);
      chk("stall_valid", {31'h0, ir_valid}, 32'h1);
    end
    push(16'h4, 4'h4); push(16'h5, 4'h5);
    ir_ready = 1'b1;
    tick();
    chk("unstall_ir", {16'h0, ir}, 32'h5);
    tick();
    ir_ready = 1'b0;
    branch_valid = 1'b1; branch_target = 4'h3;
    tick();
    branch_valid = 1'b0;
    tick();
    chk("pre_br_ir", {16'h0, ir}, 32'h3);

    // 4: branch to A while ir=3 is stalled; ir=3 is flushed.
    branch_valid = 1'b1; branch_target = 4'hA;
    tick();
    branch_valid = 1'b0;
    chk("br_valid", {31'h0, ir_valid}, 32'h0);
    chk("br_addr", {28'h0, instruction_address}, 32'hA);
    tick();
    chk("br_ir", {16'h0, ir}, 32'hA);
    chk("br_ir_pc", {28'h0, ir_pc}, 32'hA);
    push(16'hA, 4'hA);
    ir_ready = 1'b1;
    tick();
    ir_ready = 1'b0;

    // 5: halt word at address 5; reach it via a branch to 3.
    r_mem[5] = 16'hF000;
    branch_valid = 1'b1; branch_target = 4'h3;
    tick();
    branch_valid = 1'b0;
    push(16'h3, 4'h3); push(16'h4, 4'h4); push(16'hF000, 4'h5);
    ir_ready = 1'b1;
    tick(); tick(); tick();
    ir_ready = 1'b0;
    chk("halt_ir", {16'h0, ir}, 32'hF000);
    chk("halt_flag", {31'h0, halted}, 32'h1);
    chk("halt_addr", {28'h0, instruction_address}, 32'h6);
    branch_valid = 1'b1; branch_target = 4'h9;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("halted_addr_hold", {28'h0, instruction_address}, 32'h6);
      chk("halted_valid_hold", {31'h0, ir_valid}, 32'h1);
      chk("halted_ir_hold", {16'h0, ir}, 32'hF000);
    end
    ir_ready = 1'b1;
    tick();
    branch_valid = 1'b0;
    chk("halt_consumed", {31'h0, ir_valid}, 32'h0);
    chk("halt_still", {31'h0, halted}, 32'h1);
    ir_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_halted", {31'h0, halted}, 32'h0);
    chk("restart_addr", {28'h0, instruction_address}, 32'h0);
    chk("restart_valid", {31'h0, ir_valid}, 32'h0);
    push(16'h0, 4'h0);
    ir_ready = 1'b1;
    tick();
    chk("restart_ir", {16'h0, ir}, 32'h0);
    tick();
    ir_ready = 1'b0;
    chk("restart_ir2", {16'h0, ir}, 32'h1);

    // 6: asynchronous reset between edges while ir_valid is high.
    #2;
    clr = 1'b0;
    #1;
    chk("async_valid", {31'h0, ir_valid}, 32'h0);
    chk("async_addr", {28'h0, instruction_address}, 32'h0);
    chk("async_ir", {16'h0, ir}, 32'h0);
    tick();
    clr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_valid", {31'h0, ir_valid}, 32'h0);
      chk("post_rst_addr", {28'h0, instruction_address}, 32'h0);
    end

    chk("queue_empty", 32'(r_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
